// File: rtl/qproc_pkg.sv
// qproc_pkg: shared state encoding and time width for the qproc timed dispatcher.
package qproc_pkg;
    localparam int TIME_W = 48;
    typedef enum logic [1:0] {ST_EMPTY, ST_WAIT, ST_FIRE} state_e;
endpackage

// File: rtl/qproc_time_dispatch_if.sv
// qproc_time_dispatch_if: push handshake from the processor and fire outputs of the dispatcher.
interface qproc_time_dispatch_if #(
    parameter int DW = 32,
    parameter int TW = qproc_pkg::TIME_W
);
    logic          push_valid;
    logic          push_ready;
    logic [TW-1:0] push_time;
    logic [DW-1:0] push_data;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [TW-1:0] out_time;
    logic          late;
    modport master (
        output push_valid, push_time, push_data,
        input  push_ready, out_valid, out_data, out_time, late
    );
    modport slave (
        input  push_valid, push_time, push_data,
        output push_ready, out_valid, out_data, out_time, late
    );
endinterface

// File: rtl/qproc_time_fifo.sv
// qproc_time_fifo: DEPTH x W storage behind the head register; flop array read at the read pointer.
module qproc_time_fifo #(
    parameter  int DEPTH = 8,
    parameter  int W     = 80,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  cnt
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          wr, rd;

    always_comb begin
        wr       = wr_en && !full && !flush;
        rd       = rd_en && !empty && !flush;
        wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(wr);
        rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(rd);
        cnt_d    = flush ? '0 : cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem[rd_ptr_q];
    assign full    = cnt_q == (AW+1)'(DEPTH);
    assign empty   = cnt_q == '0;
    assign cnt     = cnt_q;
endmodule

// File: rtl/qproc_time_dispatch.sv
// qproc_time_dispatch: releases queued {time,data} words in push order once time_abs reaches them.
// The head entry lives in a register outside the FIFO; occupancy counts it while in ST_WAIT.
module qproc_time_dispatch
    import qproc_pkg::*;
#(
    parameter  int DEPTH = 8,
    parameter  int DW    = 32,
    parameter  int TW    = TIME_W,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic                  t_clk_i,
    input  logic                  t_rst_ni,
    input  logic [TW-1:0]         time_abs_i,
    input  logic                  flush_i,
    qproc_time_dispatch_if.slave  bus,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [CW-1:0]         cnt_o
);
    state_e           state_q, state_d;
    logic [TW-1:0]    head_time_q, head_time_d, out_time_q, out_time_d, diff;
    logic [DW-1:0]    head_data_q, head_data_d, out_data_q, out_data_d;
    logic             late_q, late_d, due, push_acc, fifo_wr, fifo_rd, fifo_full, fifo_empty;
    logic [TW+DW-1:0] fifo_rdata;
    logic [CW-1:0]    fifo_cnt;

    qproc_time_fifo #(.DEPTH(DEPTH), .W(TW + DW)) u_fifo (
        .clk    (t_clk_i),
        .rst_n  (t_rst_ni),
        .flush  (flush_i),
        .wr_en  (fifo_wr),
        .wr_data({bus.push_time, bus.push_data}),
        .rd_en  (fifo_rd),
        .rd_data(fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .cnt    (fifo_cnt)
    );

    always_comb begin
        diff        = head_time_q - time_abs_i;
        due         = diff[TW-1] || diff == '0;
        push_acc    = bus.push_valid && bus.push_ready;
        state_d     = state_q;
        head_time_d = head_time_q;
        head_data_d = head_data_q;
        out_time_d  = out_time_q;
        out_data_d  = out_data_q;
        late_d      = late_q;
        fifo_rd     = 1'b0;
        fifo_wr     = push_acc;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else if (state_q == ST_WAIT) begin
            if (due) begin
                out_time_d = head_time_q;
                out_data_d = head_data_q;
                late_d     = diff[TW-1];
                state_d    = ST_FIRE;
            end
        end else if (!fifo_empty) begin
            fifo_rd                    = 1'b1;
            {head_time_d, head_data_d} = fifo_rdata;
            state_d                    = ST_WAIT;
        end else if (push_acc) begin
            // Nothing older is queued, so the push goes straight to the head register.
            fifo_wr     = 1'b0;
            head_time_d = bus.push_time;
            head_data_d = bus.push_data;
            state_d     = ST_WAIT;
        end else begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge t_clk_i or negedge t_rst_ni) begin
        if (!t_rst_ni) begin
            state_q     <= ST_EMPTY;
            head_time_q <= '0;
            head_data_q <= '0;
            out_time_q  <= '0;
            out_data_q  <= '0;
            late_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_time_q <= head_time_d;
            head_data_q <= head_data_d;
            out_time_q  <= out_time_d;
            out_data_q  <= out_data_d;
            late_q      <= late_d;
        end
    end

    assign cnt_o          = fifo_cnt + CW'(state_q == ST_WAIT);
    assign full_o         = cnt_o == CW'(DEPTH);
    assign empty_o        = cnt_o == '0;
    assign bus.push_ready = !full_o && !fifo_full && !flush_i;
    assign bus.out_valid  = state_q == ST_FIRE;
    assign bus.out_data   = out_data_q;
    assign bus.out_time   = out_time_q;
    assign bus.late       = late_q && state_q == ST_FIRE;
endmodule
